// File: rtl/control_path.sv
// control_path: game-flow controller for the rhythm game.
//
// Sequences the title screen, active play, win screen and lose screen,
// and drives one-hot screen-select flags for the renderer and the
// note-address counter.
//
// Ports
//   clk         in   system clock
//   resetn      in   synchronous, active-low reset
//   key_1       in   start/retry pushbutton (raw, active-low, asynchronous)
//   key_2       in   back-to-title pushbutton (raw, active-low, asynchronous)
//   miss        in   miss strobe from datapath; each rising edge is one missed note
//   done        in   song-finished level from datapath
//   iface       out  title ("interface") screen active; the flag cannot carry
//                    its natural name because "interface" is a reserved word
//   map         out  play screen active
//   total_miss  out  miss count has reached MISS_LIMIT
//   win         out  win screen active
//   lose        out  lose screen active
//
// Parameters
//   MISS_LIMIT       missed notes that end the game as a loss
//   MISS_W           miss counter width, 2**MISS_W must exceed MISS_LIMIT
//   DEBOUNCE_CYCLES  stable-sample count for the key debouncer
//
// Build option
//   DEBOUNCE_EN  when defined, each synchronized key is debounced for
//                DEBOUNCE_CYCLES clocks before press detection; when
//                undefined, presses are detected directly on the
//                synchronized key.

// Per-key conditioning: synchronizer, optional debouncer and a
// high-to-low press detector. Sync and history flops reset to 1 (key
// released) so no false press appears after reset.
module key_press #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic press
);

    logic sync1;
    logic sync2;
    logic level;
    logic prev;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             debounced;
    logic [CNT_W-1:0] cnt;

    // The debounced value flips only after DEBOUNCE_CYCLES consecutive
    // samples that disagree with it; any agreeing sample restarts the count.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            debounced <= 1'b1;
            cnt       <= '0;
        end else if (sync2 == debounced) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            debounced <= sync2;
            cnt       <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign level = debounced;
`else
    assign level = sync2;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            prev <= 1'b1;
        end else begin
            prev <= level;
        end
    end

    assign press = !level && prev;

endmodule

module control_path #(
    parameter int MISS_LIMIT      = 10,
    parameter int MISS_W          = 8,
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic resetn,
    input  logic key_1,
    input  logic key_2,
    input  logic miss,
    input  logic done,
    output logic iface,
    output logic map,
    output logic total_miss,
    output logic win,
    output logic lose
);

    typedef enum logic [1:0] {
        TITLE = 2'd0,
        PLAY  = 2'd1,
        WIN   = 2'd2,
        LOSE  = 2'd3
    } state_t;

    // One extra bit so count + miss_rise never wraps before the compare.
    localparam logic [MISS_W:0] LIMIT = MISS_LIMIT[MISS_W:0];

    state_t            state;
    state_t            state_next;
    logic [MISS_W-1:0] count;
    logic [MISS_W-1:0] count_next;
    logic [MISS_W:0]   miss_sum;
    logic              miss_prev;
    logic              miss_rise;
    logic              press_1;
    logic              press_2;

    key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_1 (
        .clk    (clk),
        .resetn (resetn),
        .key    (key_1),
        .press  (press_1)
    );

    key_press #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_2 (
        .clk    (clk),
        .resetn (resetn),
        .key    (key_2),
        .press  (press_2)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= TITLE;
            count     <= '0;
            miss_prev <= 1'b0;
        end else begin
            state     <= state_next;
            count     <= count_next;
            miss_prev <= miss;
        end
    end

    assign miss_rise = miss && !miss_prev;
    assign miss_sum  = {1'b0, count} + {{MISS_W{1'b0}}, miss_rise};

    // In PLAY the loss check looks at the count including this cycle's
    // miss, so a limit-reaching miss beats a simultaneous done. In WIN and
    // LOSE key_2 is tested first so a double press returns to the title.
    always_comb begin
        state_next = state;
        count_next = count;
        case (state)
            TITLE: begin
                if (press_1) begin
                    state_next = PLAY;
                    count_next = '0;
                end
            end
            PLAY: begin
                if (miss_sum >= LIMIT) begin
                    state_next = LOSE;
                    count_next = LIMIT[MISS_W-1:0];
                end else if (done) begin
                    state_next = WIN;
                    count_next = miss_sum[MISS_W-1:0];
                end else if (press_2) begin
                    state_next = TITLE;
                    count_next = '0;
                end else begin
                    count_next = miss_sum[MISS_W-1:0];
                end
            end
            WIN, LOSE: begin
                if (press_2) begin
                    state_next = TITLE;
                    count_next = '0;
                end else if (press_1) begin
                    state_next = PLAY;
                    count_next = '0;
                end
            end
            default: begin
                state_next = TITLE;
                count_next = '0;
            end
        endcase
    end

    assign iface      = (state == TITLE);
    assign map        = (state == PLAY);
    assign win        = (state == WIN);
    assign lose       = (state == LOSE);
    assign total_miss = ({1'b0, count} >= LIMIT);

endmodule

// File: tb/tb_control_path.sv
// tb_control_path: directed self-checking bench for control_path.
// Run either with DEBOUNCE_EN undefined, or defined with DEBOUNCE_CYCLES=4.
module tb_control_path;

`ifdef DEBOUNCE_EN
    localparam int EX = 4;
`else
    localparam int EX = 0;
`endif

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic key_1 = 1'b1;
    logic key_2 = 1'b1;
    logic miss = 1'b0;
    logic done = 1'b0;
    logic iface, map, total_miss, win, lose;

    int total = 0;
    int bad = 0;

    control_path #(
        .MISS_LIMIT(10),
        .MISS_W(8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .key_1      (key_1),
        .key_2      (key_2),
        .miss       (miss),
        .done       (done),
        .iface      (iface),
        .map        (map),
        .total_miss (total_miss),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Press (and then release) the selected keys; the transition lands
    // inside the first wait.
    task automatic press(input bit p1, input bit p2);
        if (p1) key_1 = 1'b0;
        if (p2) key_2 = 1'b0;
        tick(3 + EX);
        key_1 = 1'b1;
        key_2 = 1'b1;
        tick(3 + EX);
    endtask

    task automatic miss_pulse();
        miss = 1'b1;
        tick(1);
        miss = 1'b0;
        tick(1);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(2);
        total++;
        if ({iface, map, win, lose} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL reset_screens got=%b want=1000", {iface, map, win, lose});
        end
        total++;
        if (total_miss !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_total_miss got=%b want=0", total_miss);
        end
        resetn = 1'b1;
        tick(1);
        // miss, done and key_2 are all ignored on the title screen
        miss_pulse();
        done = 1'b1;
        tick(2);
        done = 1'b0;
        press(1'b0, 1'b1);
        total++;
        if ({iface, map, win, lose} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL title_ignores got=%b want=1000", {iface, map, win, lose});
        end
    endtask

    task automatic test_key_hold();
        key_1 = 1'b0;
        tick(1);
        total++;
        if (map !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_edge_n got=%b want=0", map);
        end
        tick(1 + EX);
        total++;
        if (map !== 1'b0) begin
            bad++;
            $display("[TB] FAIL hold_edge_n1 got=%b want=0", map);
        end
        tick(1);
        total++;
        if ({iface, map, win, lose} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL hold_edge_n2 got=%b want=0100", {iface, map, win, lose});
        end
        for (int i = 0; i < 17 - EX; i++) begin
            tick(1);
            total++;
            if ({iface, map, win, lose} !== 4'b0100) begin
                bad++;
                $display("[TB] FAIL hold_stays_play cyc=%0d got=%b want=0100", i, {iface, map, win, lose});
            end
        end
        key_1 = 1'b1;
        tick(6 + EX);
        total++;
        if ({iface, map, win, lose} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL release_stays_play got=%b want=0100", {iface, map, win, lose});
        end
    endtask

    task automatic test_win();
        for (int i = 0; i < 9; i++) miss_pulse();
        total++;
        if ({map, total_miss} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL nine_miss_play got=%b want=10", {map, total_miss});
        end
        done = 1'b1;
        tick(1);
        done = 1'b0;
        total++;
        if ({iface, map, win, lose} !== 4'b0010) begin
            bad++;
            $display("[TB] FAIL win_state got=%b want=0010", {iface, map, win, lose});
        end
        total++;
        if (total_miss !== 1'b0) begin
            bad++;
            $display("[TB] FAIL win_total_miss got=%b want=0", total_miss);
        end
    endtask

    task automatic test_both_keys_win();
        press(1'b1, 1'b1);
        total++;
        if ({iface, map, win, lose} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL both_keys_title got=%b want=1000", {iface, map, win, lose});
        end
    endtask

    task automatic test_lose();
        press(1'b1, 1'b0);
        total++;
        if ({map, total_miss} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL enter_play got=%b want=10", {map, total_miss});
        end
        // a held miss counts once
        miss = 1'b1;
        tick(5);
        miss = 1'b0;
        tick(1);
        for (int i = 0; i < 8; i++) miss_pulse();
        total++;
        if ({map, total_miss} !== 2'b10) begin
            bad++;
            $display("[TB] FAIL nine_counted_play got=%b want=10", {map, total_miss});
        end
        miss = 1'b1;
        tick(1);
        total++;
        if ({iface, map, win, lose, total_miss} !== 5'b00011) begin
            bad++;
            $display("[TB] FAIL tenth_miss_lose got=%b want=00011", {iface, map, win, lose, total_miss});
        end
        miss = 1'b0;
        done = 1'b1;
        tick(4);
        done = 1'b0;
        total++;
        if ({lose, total_miss} !== 2'b11) begin
            bad++;
            $display("[TB] FAIL lose_held got=%b want=11", {lose, total_miss});
        end
    endtask

    task automatic test_lose_retry();
        press(1'b1, 1'b0);
        total++;
        if ({iface, map, win, lose, total_miss} !== 5'b01000) begin
            bad++;
            $display("[TB] FAIL retry_play got=%b want=01000", {iface, map, win, lose, total_miss});
        end
    endtask

    task automatic test_miss_done_same();
        for (int i = 0; i < 9; i++) miss_pulse();
        miss = 1'b1;
        done = 1'b1;
        tick(1);
        miss = 1'b0;
        done = 1'b0;
        total++;
        if ({iface, map, win, lose, total_miss} !== 5'b00011) begin
            bad++;
            $display("[TB] FAIL miss_done_lose got=%b want=00011", {iface, map, win, lose, total_miss});
        end
        press(1'b0, 1'b1);
        total++;
        if ({iface, map, win, lose, total_miss} !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL lose_key2_title got=%b want=10000", {iface, map, win, lose, total_miss});
        end
    endtask

    task automatic test_play_back_and_reset();
        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        total++;
        if ({iface, map, win, lose} !== 4'b0100) begin
            bad++;
            $display("[TB] FAIL play_ignores_key1 got=%b want=0100", {iface, map, win, lose});
        end
        press(1'b0, 1'b1);
        total++;
        if ({iface, map, win, lose} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL play_key2_title got=%b want=1000", {iface, map, win, lose});
        end
        press(1'b1, 1'b0);
        miss_pulse();
        miss_pulse();
        key_1 = 1'b0;
        resetn = 1'b0;
        tick(1);
        total++;
        if ({iface, map, win, lose, total_miss} !== 5'b10000) begin
            bad++;
            $display("[TB] FAIL mid_reset got=%b want=10000", {iface, map, win, lose, total_miss});
        end
        key_1 = 1'b1;
        resetn = 1'b1;
        tick(6 + EX);
        total++;
        if ({iface, map, win, lose} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL reset_discards_press got=%b want=1000", {iface, map, win, lose});
        end
    endtask

    initial begin
        test_reset();
        test_key_hold();
        test_win();
        test_both_keys_win();
        test_lose();
        test_lose_retry();
        test_miss_done_same();
        test_play_back_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_path.md
Name: control_path

Overview:
- Top-level game-flow controller for the rhythm game.
- Sequences the title screen, active play (notes scrolling), win screen and lose screen.
- Inputs: two pushbuttons, a per-note miss strobe and a song-done flag from the datapath.
- Outputs: one-hot screen-select flags that drive the renderer and the note-address counter.

Parameters:
- MISS_LIMIT, default 10: number of missed notes that ends the game as a loss.
- MISS_W, default 8: width of the internal miss counter; must satisfy 2^MISS_W > MISS_LIMIT.
- DEBOUNCE_CYCLES, default 250000: stable-sample count used only when DEBOUNCE_EN is defined.

Ports:
- clk  in  1  system clock (50 MHz).
- resetn  in  1  reset, synchronous, active-low.
- key_1  in  1  start/retry pushbutton, raw, active-low, asynchronous.
- key_2  in  1  back-to-title pushbutton, raw, active-low, asynchronous.
- miss  in  1  miss indication from datapath, synchronous to clk; each rising edge is one missed note.
- done  in  1  song finished, level, synchronous to clk.
- interface  out  1  high in TITLE state.
- map  out  1  high in PLAY state.
- total_miss  out  1  high when miss count is at or above MISS_LIMIT.
- win  out  1  high in WIN state.
- lose  out  1  high in LOSE state.

Behaviour:
- Clock and reset: clock clk; reset resetn, synchronous, active-low.
- Reset state: state=TITLE, miss count=0, all key/miss history registers=1/0 idle.
  - Resulting outputs: interface=1, map=0, win=0, lose=0, total_miss=0.
- States: TITLE, PLAY, WIN, LOSE in a registered state register.
  - Outputs are Moore decodes of the state register.
  - interface, map, win and lose are mutually exclusive; exactly one is high.
- Key handling:
  - Each key passes through a 2-flop synchronizer, then a registered previous-value flop.
  - press = sync2==0 && prev==1, i.e. a high-to-low transition.
  - A key first sampled low at edge N yields a state change at edge N+2.
  - Holding a key produces exactly one press; release produces none.
- Miss handling:
  - miss_rise = miss && !miss_prev, where miss_prev is registered every cycle.
  - In PLAY, miss_rise increments the count, which saturates at MISS_LIMIT.
  - Outside PLAY, miss is ignored.
  - total_miss = (count >= MISS_LIMIT), decoded from the count register.
- Transitions, evaluated each edge, with priority as listed:
  - TITLE:
    - key_1 press -> PLAY; count cleared to 0.
    - key_2 ignored.
    - done and miss ignored.
  - PLAY:
    1. If next count (count plus this cycle's miss_rise) >= MISS_LIMIT -> LOSE.
    2. Else if done=1 -> WIN.
    3. Else if key_2 press -> TITLE; count cleared.
    4. key_1 ignored.
  - WIN and LOSE:
    - key_2 press -> TITLE; count cleared.
    - Else key_1 press -> PLAY; count cleared.
    - Count held otherwise, so total_miss stays high throughout LOSE.
- Simultaneous events:
  - A limit-reaching miss and done in the same cycle -> LOSE.
  - key_1 and key_2 pressed in the same cycle in WIN/LOSE -> TITLE.
- Entering PLAY always starts from count=0 and total_miss=0.
- Reset mid-operation: returns to TITLE on the same edge regardless of state; pending key presses are discarded.

Optional Feature:
- Macro DEBOUNCE_EN.
- Defined:
  - After the synchronizer, each key has a counter.
  - The debounced key value changes only after the synchronized value has differed from the debounced value for DEBOUNCE_CYCLES consecutive clocks.
  - The counter resets to 0 on any sample that matches the debounced value.
  - Press detection operates on the debounced value; added latency is DEBOUNCE_CYCLES clocks.
- Undefined: no debounce logic; press detection operates directly on the synchronized value with the latency stated above.
- Benches run undefined, or with DEBOUNCE_CYCLES=4.

Test Plan:
- Reset with resetn=0 for 2 cycles -> interface=1, map=0, win=0, lose=0, total_miss=0.
- From TITLE, drive key_1 low at edge N and hold for 20 cycles -> map=1 from edge N+2, single transition; release -> stays PLAY.
- In PLAY, give 9 single-cycle miss pulses then done=1 -> WIN (win=1, total_miss=0).
- In PLAY, give 10 miss pulses -> LOSE on the 10th pulse's edge (lose=1, total_miss=1).
  - A miss held high for 5 cycles counts once.
- In PLAY with count=9, assert the 10th miss pulse and done in the same cycle -> LOSE.
- In LOSE:
  - key_1 press -> PLAY with total_miss=0.
  - Then key_2 press -> TITLE.
  - Both keys pressed together in WIN -> TITLE.
